// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the multicycle core's mem_read/mem_write/
//   mem_resp handshake. It serves instruction fetches, loads and stores from
//   a word array with per-byte write enables. The response latency can be
//   configured so that benches can stress the core's wait states.
//
// Parameters
//   ADDR_BITS : word-index width, depth = 2**ADDR_BITS words
//   LATENCY   : cycles from the request-accept cycle to the mem_resp cycle (1..15)
//
// Ports
//   clk             in   1   clock, rising edge
//   rst             in   1   asynchronous reset, active-low
//   mem_read        in   1   read request, held until mem_resp
//   mem_write       in   1   write request, held until mem_resp
//   mem_byte_enable in   4   write byte lanes (ignored on reads)
//   mem_address     in   32  byte address, bits [1:0] ignored
//   mem_wdata       in   32  write data
//   mem_rdata       out  32  read data, valid in the mem_resp cycle of a read
//   mem_resp        out  1   one-cycle completion pulse
//   mem_err         out  1   error flag, only together with mem_resp
// ---------------------------------------------------------------------------
module mem_responder #(
   parameter int unsigned ADDR_BITS = 10,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [3:0]  mem_byte_enable,
   input  logic [31:0] mem_address,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        mem_resp,
   output logic        mem_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int unsigned DEPTH   = 2 ** ADDR_BITS;
   localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
   localparam logic        LAT_ONE = (LATENCY == 1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [3:0]             r_cnt;
   logic [3:0]             w_cnt_nxt;
   logic                   w_latch;

   // Latched request (captured in IDLE, used while BUSY)
   logic                   r_rd;
   logic                   r_wr;
   logic [3:0]             r_be;
   logic [31:0]            r_addr;
   logic [31:0]            r_wdata;

   // Operands of the access that commits on this edge
   logic                   w_op_rd;
   logic                   w_op_wr;
   logic [3:0]             w_op_be;
   logic [31:0]            w_op_addr;
   logic [31:0]            w_op_wdata;

   logic                   w_commit;
   logic                   w_oor;
   logic                   w_conflict;
   logic                   w_do_write;
   logic                   w_do_read;
   logic [ADDR_BITS-1:0]   w_idx;
   logic                   w_unused_bits;

   logic                   r_resp;
   logic                   r_err;
   logic [31:0]            r_rdata;
   logic [31:0]            r_mem [DEPTH];

   // State and latency counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic: accept in IDLE, count down in BUSY, one cycle in RESP
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (mem_read || mem_write) begin
               w_latch   = 1'b1;
               w_cnt_nxt = LAT_M1;
               if (LAT_ONE) begin
                  w_state_nxt = ST_RESP;
               end else begin
                  w_state_nxt = ST_BUSY;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_state_nxt = ST_RESP;
            end else begin
               w_state_nxt = ST_BUSY;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // Request capture register; ignored requests in BUSY never reach it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_be    <= 4'd0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
      end else if (w_latch) begin
         r_rd    <= mem_read;
         r_wr    <= mem_write;
         r_be    <= mem_byte_enable;
         r_addr  <= mem_address;
         r_wdata <= mem_wdata;
      end else begin
         r_rd    <= r_rd;
         r_wr    <= r_wr;
         r_be    <= r_be;
         r_addr  <= r_addr;
         r_wdata <= r_wdata;
      end
   end

   // With LATENCY==1 the access commits straight out of IDLE, so the live
   // inputs are the operands; otherwise the latched copy is used.
   always_comb begin
      if (r_state == ST_IDLE) begin
         w_op_rd    = mem_read;
         w_op_wr    = mem_write;
         w_op_be    = mem_byte_enable;
         w_op_addr  = mem_address;
         w_op_wdata = mem_wdata;
      end else begin
         w_op_rd    = r_rd;
         w_op_wr    = r_wr;
         w_op_be    = r_be;
         w_op_addr  = r_addr;
         w_op_wdata = r_wdata;
      end
   end

   assign w_commit      = (w_state_nxt == ST_RESP);
   assign w_oor         = |w_op_addr[31:ADDR_BITS+2];
   assign w_idx         = w_op_addr[ADDR_BITS+1:2];
   assign w_conflict    = w_op_rd & w_op_wr;
   assign w_do_write    = w_commit & w_op_wr & ~w_op_rd & ~w_oor;
   assign w_do_read     = w_commit & w_op_rd & ~w_op_wr;
   assign w_unused_bits = ^w_op_addr[1:0];

   // Registered outputs, updated on the edge entering RESP
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_resp  <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= 32'h0;
      end else begin
         r_resp <= w_commit;
         r_err  <= w_commit & (w_oor | w_conflict);
         if (w_do_read) begin
            r_rdata <= w_oor ? 32'h0 : r_mem[w_idx];
         end else begin
            r_rdata <= r_rdata;
         end
      end
   end

   // Backing store, not reset; per-byte lane writes at commit
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (w_do_write && w_op_be[i]) begin
            r_mem[w_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
         end
      end
   end

   assign mem_resp  = r_resp;
   assign mem_err   = r_err;
   assign mem_rdata = r_rdata;

endmodule
